// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and overflow resolve in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       div_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_result;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_spec_res;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_final;

  // div_ctrl[0] marks unsigned, div_ctrl[1] selects remainder.
  assign w_a_neg    = !div_ctrl[0] && op_a[WIDTH-1];
  assign w_b_neg    = !div_ctrl[0] && op_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -op_a : op_a;
  assign w_b_mag    = w_b_neg ? -op_b : op_b;
  assign w_div0     = (op_b == '0);
  assign w_ovf      = !div_ctrl[0] && (op_a == W_MIN) && (op_b == '1);
  assign w_special  = w_div0 || w_ovf;
  assign w_spec_res = w_div0 ? (div_ctrl[1] ? op_a : '1)
                             : (div_ctrl[1] ? '0 : W_MIN);
  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_last     = (r_cnt == CNT_LAST);

  // Restoring step: shift next dividend bit into the partial remainder.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_sub     = w_shift[WIDTH-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_final   = r_is_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                              : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start) w_next = w_special ? S_DONE : S_CALC;
        S_CALC:  if (w_last) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs; a flush in the done cycle suppresses the pulse.
  always_comb begin
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE) && !flush;
    result = r_result;
  end

  // Datapath: operand capture, iteration, and result write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_is_rem <= div_ctrl[1];
      if (w_special) begin
        r_result <= w_spec_res;
      end else begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_a_mag;
        r_dvs   <= w_b_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
    end else if (r_state == S_CALC && !flush) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_final;
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port div_ctrl, input, 2 bits: operation select; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port op_a, input, WIDTH bits: dividend, sampled with start.
REQ-007 SHALL have port op_b, input, WIDTH bits: divisor, sampled with start.
REQ-008 SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-009 SHALL have port busy, output, 1 bit: high while in CALC or DONE.
REQ-010 SHALL have port done, output, 1 bit: high for exactly one cycle when result is valid.
REQ-011 SHALL have port result, output, WIDTH bits: quotient or remainder selected by the latched div_ctrl.

Function
REQ-012 SHALL implement three states, IDLE, CALC and DONE, with the transitions given in REQ-013 to REQ-016.
REQ-013 IDLE & start & !flush, normal operands: SHALL latch operands and div_ctrl, clear the iteration counter, and go to CALC.
REQ-014 IDLE & start & !flush, special operands: SHALL go directly to DONE with the special result of REQ-019/REQ-020.
REQ-015 CALC: SHALL perform one restoring shift-subtract step per cycle on magnitudes for WIDTH cycles, then go to DONE.
REQ-016 DONE: SHALL assert done and return to IDLE unconditionally on the next edge.
REQ-017 Latency: start in cycle 0 SHALL give done in cycle WIDTH+1 (33 for WIDTH=32) for normal operands, and in cycle 1 for special operands.
REQ-018 Signed ops (DIV, REM): SHALL divide operand magnitudes; the quotient SHALL be negated when the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-019 Divide by zero (op_b=0): the quotient SHALL be all ones; the remainder SHALL equal op_a; this applies to signed and unsigned ops alike.
REQ-020 Signed overflow (op_a=most negative value, op_b=-1, DIV/REM only): the quotient SHALL be the most negative value and the remainder SHALL be 0.
REQ-021 result SHALL be registered, SHALL be valid in the done cycle, and SHALL be held until the next accepted start.
REQ-022 start SHALL be ignored while busy; the latched operands SHALL be unaffected.
REQ-023 flush SHALL force IDLE on the next edge from any state, suppress done, and leave result unchanged.
REQ-024 flush and start asserted in the same IDLE cycle: flush SHALL win and no operation SHALL start.
REQ-025 Operand inputs SHALL be don't-care in every cycle except one where start is accepted.

Reset
REQ-026 rst low SHALL immediately force IDLE, busy=0, done=0, result=0 and counter=0, independent of clk.
REQ-027 rst asserted mid-CALC SHALL discard the operation; no done SHALL follow deassertion.
REQ-028 After rst deasserts, the first accepted start SHALL behave exactly per REQ-013/REQ-014.

Verification
REQ-029 DIVU 100/7, start cycle 0 -> busy cycles 1-33, done in cycle 33 only, result=14; REMU -> result=2.
REQ-030 DIV -7/2 -> result=-3 (0xFFFFFFFD); REM -7/2 -> result=-1; REM 7/-2 -> result=1.
REQ-031 DIV 5/0 -> done in cycle 1, result=0xFFFFFFFF; REMU 5/0 -> result=5; DIV 0x80000000/-1 -> 0x80000000; REM of the same operands -> 0.
REQ-032 start DIVU 9/3, flush in cycle 10 -> busy=0 from cycle 11, no done pulse, result keeps its prior value; a new start in cycle 11 -> done in cycle 44.
REQ-033 start pulsed again in cycles 5 and 33 during an operation -> ignored; single done in cycle 33 with the first result.
REQ-034 rst low in cycle 20 of an operation, released in cycle 22 -> outputs 0 immediately, no done ever; the next DIVU 8/2 -> result=4.
